// File: rtl/peripheral_pkg.sv
// Shared definitions for the Clause 22 MDIO management-frame slave.
package peripheral_pkg;

  localparam int unsigned PHYAD_W = 5;
  localparam int unsigned REGAD_W = 5;
  localparam int unsigned DATA_W  = 16;

  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_READ  = 2'b10;

  typedef enum logic [3:0] {
    StIdle,
    StSt1,
    StOp,
    StHdr,
    StWrTa,
    StWrData,
    StRdTa,
    StRdData,
    StDone
  } state_e;

endpackage

// File: rtl/peripheral.sv
// MDIO (IEEE 802.3 Clause 22) slave: decodes serial frames into register-file
// write strobes and serialises register reads back onto MDIO_IN.
module peripheral
  import peripheral_pkg::*;
(
  input  logic                MDC,
  input  logic                RESET,
  input  logic                MDIO_OUT,
  input  logic                MDIO_OE,
  input  logic [DATA_W-1:0]   RD_DATA,
  output logic                MDIO_DONE,
  output logic                MDIO_IN,
  output logic [REGAD_W-1:0]  ADDR,
  output logic [DATA_W-1:0]   WR_DATA,
  output logic                WR_STB
);

  state_e              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [DATA_W-1:0]   sh_q, sh_d;
  logic                is_rd_q, is_rd_d;
  logic [REGAD_W-1:0]  addr_q, addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic                mdio_in_q, mdio_in_d;
  logic [1:0]          op;

  always_ff @(posedge MDC) begin
    if (RESET) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      sh_q      <= '0;
      is_rd_q   <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= '0;
      mdio_in_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      is_rd_q   <= is_rd_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      mdio_in_q <= mdio_in_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    sh_d      = sh_q;
    is_rd_d   = is_rd_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    mdio_in_d = 1'b0;
    op        = {sh_q[0], MDIO_OUT};

    unique case (state_q)
      // DONE also looks for a start bit so frames can follow with no idle gap.
      StIdle, StDone: begin
        cnt_d   = '0;
        state_d = (MDIO_OE && (MDIO_OUT == 1'b0)) ? StSt1 : StIdle;
      end
      StSt1: begin
        cnt_d   = '0;
        state_d = (MDIO_OE && (MDIO_OUT == 1'b1)) ? StOp : StIdle;
      end
      StOp: begin
        if (!MDIO_OE) begin
          state_d = StIdle;
        end else if (cnt_q == 5'd0) begin
          sh_d[0] = MDIO_OUT;
          cnt_d   = 5'd1;
        end else begin
          cnt_d = '0;
          // Unknown opcode bits fail both compares and drop the frame.
          if (op == OP_WRITE) begin
            is_rd_d = 1'b0;
            state_d = StHdr;
          end else if (op == OP_READ) begin
            is_rd_d = 1'b1;
            state_d = StHdr;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StHdr: begin
        if (!MDIO_OE) begin
          state_d = StIdle;
        end else begin
          if (cnt_q >= 5'(PHYAD_W)) addr_d = {addr_q[REGAD_W-2:0], MDIO_OUT};
          if (cnt_q == 5'(PHYAD_W + REGAD_W - 1)) begin
            cnt_d   = '0;
            state_d = is_rd_q ? StRdTa : StWrTa;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      StWrTa: begin
        if (!MDIO_OE) begin
          state_d = StIdle;
        end else if (cnt_q == 5'd1) begin
          cnt_d   = '0;
          state_d = StWrData;
        end else begin
          cnt_d = 5'd1;
        end
      end
      StWrData: begin
        if (!MDIO_OE) begin
          state_d = StIdle;
        end else begin
          sh_d = {sh_q[DATA_W-2:0], MDIO_OUT};
          if (cnt_q == 5'(DATA_W - 1)) begin
            wr_data_d = {sh_q[DATA_W-2:0], MDIO_OUT};
            cnt_d     = '0;
            state_d   = StDone;
          end else begin
            cnt_d = cnt_q + 5'd1;
          end
        end
      end
      StRdTa: begin
        if (cnt_q == 5'd0) begin
          cnt_d = 5'd1;
        end else begin
          sh_d      = {RD_DATA[DATA_W-2:0], 1'b0};
          mdio_in_d = RD_DATA[DATA_W-1];
          cnt_d     = '0;
          state_d   = StRdData;
        end
      end
      StRdData: begin
        // Bit 15 went out on entry; 15 shifts follow, then one cycle to finish.
        if (cnt_q == 5'(DATA_W - 1)) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          mdio_in_d = sh_q[DATA_W-1];
          sh_d      = {sh_q[DATA_W-2:0], 1'b0};
          cnt_d     = cnt_q + 5'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign MDIO_DONE = (state_q == StDone);
  assign WR_STB    = (state_q == StDone) && !is_rd_q;
  assign MDIO_IN   = mdio_in_q;
  assign ADDR      = addr_q;
  assign WR_DATA   = wr_data_q;

endmodule

// File: tb/tb_peripheral.sv
// Randomised frame-level bench for the MDIO slave against a transaction model.
module tb_peripheral;

  localparam int KindWr  = 0;
  localparam int KindRd  = 1;
  localparam int KindBad = 2;
  localparam int KindAbt = 3;

  logic        MDC = 1'b0;
  logic        RESET;
  logic        MDIO_OUT;
  logic        MDIO_OE;
  logic [15:0] RD_DATA;
  logic        MDIO_DONE;
  logic        MDIO_IN;
  logic [4:0]  ADDR;
  logic [15:0] WR_DATA;
  logic        WR_STB;

  peripheral dut (
    .MDC       (MDC),
    .RESET     (RESET),
    .MDIO_OUT  (MDIO_OUT),
    .MDIO_OE   (MDIO_OE),
    .RD_DATA   (RD_DATA),
    .MDIO_DONE (MDIO_DONE),
    .MDIO_IN   (MDIO_IN),
    .ADDR      (ADDR),
    .WR_DATA   (WR_DATA),
    .WR_STB    (WR_STB)
  );

  always #5 MDC = ~MDC;

  logic [15:0] rf [32];
  assign RD_DATA = rf[ADDR];

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [20:0] stb_log [$];
  logic [20:0] exp_stb [$];
  int          done_cnt = 0;
  int          exp_done = 0;
  logic [15:0] exp_wr = 16'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge MDC) begin
    if (MDIO_DONE === 1'b1) done_cnt++;
    if (WR_STB === 1'b1) begin
      stb_log.push_back({ADDR, WR_DATA});
      check("stb_with_done", {31'd0, MDIO_DONE}, 32'd1);
    end
  end

  task automatic tick(input logic oe, input logic out);
    @(negedge MDC);
    MDIO_OE  = oe;
    MDIO_OUT = out;
  endtask

  task automatic checkpoint();
    check("stb_count", stb_log.size(), exp_stb.size());
    for (int i = 0; i < exp_stb.size() && i < stb_log.size(); i++)
      check("stb_addr_data", {11'd0, stb_log[i]}, {11'd0, exp_stb[i]});
    stb_log.delete();
    exp_stb.delete();
    check("done_count", done_cnt, exp_done);
    check("wr_data_hold", {16'd0, WR_DATA}, {16'd0, exp_wr});
  endtask

  task automatic do_frame(input int kind, input logic [4:0] phy, input logic [4:0] regad,
                          input logic [15:0] data, input int pre, input int nabort,
                          input logic [1:0] badop, input int tail);
    logic [15:0] v;
    logic        eb;
    int          n;
    repeat (pre) tick(1'b1, 1'b1);
    tick(1'b1, 1'b0);
    tick(1'b1, 1'b1);
    if (kind == KindBad) begin
      tick(1'b1, badop[1]);
      tick(1'b1, badop[0]);
      repeat (28) tick(1'b0, 1'b0);
    end else begin
      if (kind == KindRd) begin
        tick(1'b1, 1'b1); tick(1'b1, 1'b0);
      end else begin
        tick(1'b1, 1'b0); tick(1'b1, 1'b1);
      end
      for (int i = 4; i >= 0; i--) tick(1'b1, phy[i]);
      for (int i = 4; i >= 0; i--) tick(1'b1, regad[i]);
      if (kind == KindRd) begin
        v = rf[regad];
        for (int k = 0; k < 18; k++) begin
          tick(1'b0, 1'($urandom));
          if (k < 2) eb = 1'b0;
          else eb = v[17-k];
          check("rd_bit", {31'd0, MDIO_IN}, {31'd0, eb});
        end
        tick(1'b0, 1'b0);
        check("rd_end_low", {31'd0, MDIO_IN}, 32'd0);
        exp_done++;
      end else begin
        tick(1'b1, 1'b1);
        tick(1'b1, 1'b0);
        n = (kind == KindAbt) ? nabort : 16;
        for (int i = 15; i >= 16 - n; i--) tick(1'b1, data[i]);
        if (kind == KindAbt) begin
          repeat (16 - n) tick(1'b0, 1'($urandom));
        end else begin
          exp_stb.push_back({regad, data});
          exp_done++;
          exp_wr    = data;
          rf[regad] = data;
        end
      end
    end
    repeat (tail) tick(1'b0, 1'b0);
  endtask

  initial begin
    int kind, tail;
    RESET    = 1'b1;
    MDIO_OE  = 1'b0;
    MDIO_OUT = 1'b0;
    for (int i = 0; i < 32; i++) rf[i] = 16'($urandom);
    repeat (3) @(negedge MDC);
    check("rst_done", {31'd0, MDIO_DONE}, 32'd0);
    check("rst_mdio_in", {31'd0, MDIO_IN}, 32'd0);
    check("rst_addr", {27'd0, ADDR}, 32'd0);
    check("rst_wr_data", {16'd0, WR_DATA}, 32'd0);
    check("rst_wr_stb", {31'd0, WR_STB}, 32'd0);
    RESET = 1'b0;

    do_frame(KindWr, 5'h00, 5'h10, 16'hABCD, 32, 0, 2'b00, 2);
    checkpoint();

    rf[16] = 16'h1234;
    do_frame(KindRd, 5'h01, 5'h10, 16'h0, 32, 0, 2'b00, 2);
    checkpoint();

    do_frame(KindBad, 5'h02, 5'h04, 16'h0, 8, 0, 2'b00, 2);
    do_frame(KindBad, 5'h02, 5'h04, 16'h0, 8, 0, 2'b11, 2);
    do_frame(KindBad, 5'h02, 5'h04, 16'h0, 8, 0, 2'bx1, 2);
    checkpoint();
    do_frame(KindWr, 5'h00, 5'h03, 16'h5A5A, 32, 0, 2'b00, 2);
    checkpoint();

    do_frame(KindAbt, 5'h00, 5'h1F, 16'hFEED, 32, 8, 2'b00, 2);
    checkpoint();

    // Reset in the middle of a read's data phase.
    repeat (4) tick(1'b1, 1'b1);
    tick(1'b1, 1'b0); tick(1'b1, 1'b1);
    tick(1'b1, 1'b1); tick(1'b1, 1'b0);
    for (int i = 0; i < 10; i++) tick(1'b1, 1'b1);
    repeat (6) tick(1'b0, 1'b0);
    RESET = 1'b1;
    @(negedge MDC);
    check("mid_rst_done", {31'd0, MDIO_DONE}, 32'd0);
    check("mid_rst_mdio_in", {31'd0, MDIO_IN}, 32'd0);
    check("mid_rst_addr", {27'd0, ADDR}, 32'd0);
    check("mid_rst_wr_data", {16'd0, WR_DATA}, 32'd0);
    check("mid_rst_wr_stb", {31'd0, WR_STB}, 32'd0);
    RESET  = 1'b0;
    exp_wr = 16'h0;
    stb_log.delete();
    exp_stb.delete();
    do_frame(KindWr, 5'h00, 5'h00, 16'h0001, 4, 0, 2'b00, 2);
    checkpoint();

    do_frame(KindWr, 5'h00, 5'h01, 16'h1111, 32, 0, 2'b00, 0);
    do_frame(KindWr, 5'h00, 5'h02, 16'h2222, 32, 0, 2'b00, 2);
    checkpoint();

    // Zero-gap writes: the second start bit lands while the first is in DONE.
    do_frame(KindWr, 5'h05, 5'h0A, 16'hC3C3, 0, 0, 2'b00, 0);
    do_frame(KindWr, 5'h06, 5'h0B, 16'h3C3C, 0, 0, 2'b00, 2);
    checkpoint();

    for (int f = 0; f < 30; f++) begin
      kind = $urandom_range(0, 3);
      tail = $urandom_range(0, 3);
      do_frame(kind, 5'($urandom), 5'($urandom), 16'($urandom), $urandom_range(0, 40),
               $urandom_range(0, 15), ($urandom_range(0, 1) != 0) ? 2'b00 : 2'b11, tail);
      if (tail >= 2) checkpoint();
    end
    repeat (3) tick(1'b0, 1'b0);
    checkpoint();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/peripheral.md
PERIPHERAL -- requirements
Module: peripheral

Interface
REQ-001 The block SHALL have no parameters; frame layout is fixed to IEEE 802.3 Clause 22: ST(2) OP(2) PHYAD(5) REGAD(5) TA(2) DATA(16), 32 bits, MSB first.
REQ-002 MDC  input  1  single clock; all logic on rising edge.
REQ-003 RESET  input  1  reset; synchronous and active-high.
REQ-004 MDIO_OUT  input  1  serial data from the MDIO controller.
REQ-005 MDIO_OE  input  1  controller drive enable; high while the controller owns the line.
REQ-006 RD_DATA  input  16  register contents for the current ADDR, supplied combinationally by the register file.
REQ-007 MDIO_DONE  output  1  one-cycle pulse at the end of a valid frame.
REQ-008 MDIO_IN  output  1  serial read data to the controller, registered.
REQ-009 ADDR  output  5  REGAD of the current or last frame.
REQ-010 WR_DATA  output  16  write data of the last write frame.
REQ-011 WR_STB  output  1  one-cycle write strobe to the register file.

Function
REQ-012 Bit sampling: MDIO_OUT SHALL be sampled only on rising MDC edges with MDIO_OE=1, except during read TA/DATA.
REQ-013 States SHALL be IDLE, ST1, OP, HDR, WR_TA, WR_DATA, RD_TA, RD_DATA, DONE.
REQ-014 IDLE: preamble ones ignored; MDIO_OE=1 and MDIO_OUT=0 -> ST1.
REQ-015 ST1: MDIO_OUT=1 -> OP; otherwise -> IDLE.
REQ-016 OP: two bits; 01 = write, 10 = read; 00 or 11 -> IDLE without DONE or strobe.
REQ-017 HDR: 10 bits (PHYAD then REGAD); PHYAD is ignored (any address accepted); REGAD is shifted into ADDR, and ADDR is valid after the edge that samples the last REGAD bit.
REQ-018 WR_TA: two bits consumed and not checked; WR_DATA: 16 bits shifted MSB first into an internal register.
REQ-019 On the edge sampling write DATA bit 0: WR_DATA SHALL update, and WR_STB and MDIO_DONE SHALL be high for exactly the next cycle (DONE state), with ADDR stable.
REQ-020 RD_TA: two cycles; MDIO_IN=0; MDIO_OE is ignored.
REQ-021 On the second TA edge, RD_DATA SHALL be latched into a shift register and MDIO_IN SHALL present bit 15.
REQ-022 Each subsequent edge SHALL shift the next lower bit onto MDIO_IN, so each bit is valid for one full MDC cycle (16 cycles).
REQ-023 After bit 0 has been presented for one cycle, MDIO_DONE SHALL pulse for one cycle and MDIO_IN SHALL return to 0; WR_STB SHALL never assert in a read frame.
REQ-024 In ST1, OP, HDR, WR_TA or WR_DATA, MDIO_OE=0 SHALL abort the frame to IDLE with no WR_STB or MDIO_DONE; WR_DATA SHALL be unchanged.
REQ-025 From DONE, the FSM SHALL return to IDLE; back-to-back frames with zero idle cycles SHALL be accepted.
REQ-026 Frame bits that are X/Z SHALL be treated as a mismatch in ST/OP; X in data is passed through unchanged.

Reset
REQ-027 RESET=1 on a rising edge SHALL force IDLE and clear MDIO_DONE, MDIO_IN, ADDR, WR_DATA, WR_STB and all shift registers/counters to 0.
REQ-028 Reset mid-frame SHALL discard the frame with no strobe, and the block SHALL resync on the next ST.

Structure
REQ-029 A shared package SHALL hold the state enum, the OP_WRITE/OP_READ constants and the field widths (PHYAD=5, REGAD=5, DATA=16).
REQ-030 The block SHALL be a single module with one 5-bit bit counter and one 16-bit shift register; no sub-module.

Verification
REQ-031 Write REGAD=0x10, DATA=0xABCD -> one WR_STB pulse with ADDR=0x10 and WR_DATA=0xABCD; MDIO_DONE pulses in the same cycle.
REQ-032 Read REGAD=0x10 with RD_DATA=0x1234 -> MDIO_IN=0,0 during TA, then 0001_0010_0011_0100 one bit per cycle; MDIO_DONE pulses once; WR_STB stays 0.
REQ-033 OP=00 and OP=11 frames -> no WR_STB, no MDIO_DONE; the next valid write of 0x5A5A to 0x03 succeeds.
REQ-034 MDIO_OE dropped after 8 data bits of a write of 0xFEED to 0x1F -> no WR_STB; WR_DATA keeps its prior value.
REQ-035 RESET asserted mid-read -> all outputs 0 on the next edge; a following write of 0x0001 to 0x00 completes normally.
REQ-036 Two back-to-back writes (0x01:0x1111, 0x02:0x2222) with 32 preamble ones before each -> two strobes, each with the correct ADDR/WR_DATA.
